// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the fetch PC, drives a request/acknowledge instruction-memory port that
// tolerates any number of wait states, and owns the IF/ID pipeline register
// consumed by decode. Accepts redirects (PCSrcD/PCBranchD) and stalls (StallD)
// from decode and the hazard unit.
//
// Build option:
//   IF_DELAY_SLOT_EN  defined   : MIPS branch delay slot; the instruction that
//                                 sequentially follows a branch is delivered.
//                     undefined : that instruction is squashed (bubble), and a
//                                 fetch still in flight at redirect time is
//                                 drained in the DISCARD state.
//
// Parameters:
//   RESET_PC   fetch address after reset (word-aligned)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   PCSrcD     in   redirect request (acted on only when StallD=0)
//   PCBranchD  in   redirect target (word-aligned)
//   StallD     in   decode cannot accept; IF/ID holds
//   ImemReq    out  fetch request
//   ImemAddr   out  fetch address, stable until acknowledged
//   ImemAck    in   one-cycle acknowledge, ImemRData valid in that cycle
//   ImemRData  in   fetched instruction
//   InstrD     out  instruction to decode (0 = nop for a bubble)
//   PCPlus4D   out  address of InstrD + 4 (0 for a bubble)
//   ValidD     out  InstrD is a real instruction
// -----------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   input  logic        StallD,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [31:0] ImemRData,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   // FETCH  : request outstanding, data goes straight to IF/ID
   // HOLD   : decode stalled on an arriving instruction, it sits in the buffer
   // DISCARD: draining a fetch that a redirect made stale
   typedef enum logic [1:0] {
      ST_FETCH   = 2'b00,
      ST_HOLD    = 2'b01,
      ST_DISCARD = 2'b10
   } state_t;

`ifdef IF_DELAY_SLOT_EN
   localparam logic DROP_SEQ = 1'b0;
`else
   localparam logic DROP_SEQ = 1'b1;
`endif

   // Wrapping word step used for every PC increment.
   function automatic logic [31:0] plus4(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

   state_t      state_r;
   logic [31:0] req_addr_r;     // address being fetched
   logic [31:0] pcf_r;          // next address to fetch
   logic [31:0] hold_instr_r;   // one-entry hold buffer: instruction
   logic [31:0] hold_pc4_r;     // one-entry hold buffer: its pc+4
   logic [31:0] instr_d_r;
   logic [31:0] pc4_d_r;
   logic        valid_d_r;

   logic        ack_s;
   logic        redirect_s;
   logic        squash_s;
   logic [31:0] req_pc4_s;
   logic [31:0] target_pc4_s;

   // Memory acknowledges are meaningless while no request is driven (HOLD).
   assign ack_s        = ImemAck & (state_r != ST_HOLD);
   assign redirect_s   = PCSrcD & ~StallD;
   // Without a delay slot the sequential successor of a branch is dropped.
   assign squash_s     = redirect_s & DROP_SEQ;
   assign req_pc4_s    = plus4(req_addr_r);
   assign target_pc4_s = plus4(PCBranchD);

   // Request is gated by rst so it drops immediately on an asynchronous reset.
   assign ImemReq  = (state_r != ST_HOLD) & ~rst;
   assign ImemAddr = req_addr_r;
   assign InstrD   = instr_d_r;
   assign PCPlus4D = pc4_d_r;
   assign ValidD   = valid_d_r;

   // Fetch FSM, PC registers, hold buffer and IF/ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_FETCH;
         req_addr_r   <= RESET_PC;
         pcf_r        <= plus4(RESET_PC);
         hold_instr_r <= 32'h0000_0000;
         hold_pc4_r   <= 32'h0000_0000;
         instr_d_r    <= 32'h0000_0000;
         pc4_d_r      <= 32'h0000_0000;
         valid_d_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (ack_s) begin
                  // Accepted ack: advance, or jump straight to the target.
                  if (redirect_s) begin
                     req_addr_r <= PCBranchD;
                     pcf_r      <= target_pc4_s;
                  end else begin
                     req_addr_r <= pcf_r;
                     pcf_r      <= plus4(pcf_r);
                  end
                  if (!StallD) begin
                     if (squash_s) begin
                        instr_d_r <= 32'h0000_0000;
                        pc4_d_r   <= 32'h0000_0000;
                        valid_d_r <= 1'b0;
                     end else begin
                        instr_d_r <= ImemRData;
                        pc4_d_r   <= req_pc4_s;
                        valid_d_r <= 1'b1;
                     end
                     state_r <= ST_FETCH;
                  end else begin
                     // Decode is busy: park the instruction and stop requesting.
                     hold_instr_r <= ImemRData;
                     hold_pc4_r   <= req_pc4_s;
                     state_r      <= ST_HOLD;
                  end
               end else begin
                  if (!StallD) begin
                     instr_d_r <= 32'h0000_0000;
                     pc4_d_r   <= 32'h0000_0000;
                     valid_d_r <= 1'b0;
                  end else begin
                     instr_d_r <= instr_d_r;
                  end
                  if (redirect_s) begin
                     // The in-flight request cannot be cancelled; fetch the
                     // target once it completes.
                     pcf_r   <= PCBranchD;
                     state_r <= DROP_SEQ ? ST_DISCARD : ST_FETCH;
                  end else begin
                     state_r <= ST_FETCH;
                  end
               end
            end

            ST_HOLD: begin
               if (!StallD) begin
                  if (squash_s) begin
                     instr_d_r <= 32'h0000_0000;
                     pc4_d_r   <= 32'h0000_0000;
                     valid_d_r <= 1'b0;
                  end else begin
                     instr_d_r <= hold_instr_r;
                     pc4_d_r   <= hold_pc4_r;
                     valid_d_r <= 1'b1;
                  end
                  // No request is outstanding here, so a redirect takes
                  // effect on the very next request.
                  if (redirect_s) begin
                     req_addr_r <= PCBranchD;
                     pcf_r      <= target_pc4_s;
                  end else begin
                     req_addr_r <= req_addr_r;
                  end
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_HOLD;
               end
            end

            ST_DISCARD: begin
               if (!StallD) begin
                  instr_d_r <= 32'h0000_0000;
                  pc4_d_r   <= 32'h0000_0000;
                  valid_d_r <= 1'b0;
               end else begin
                  instr_d_r <= instr_d_r;
               end
               if (ack_s) begin
                  // Stale data is dropped; the pending target (PCF) is next.
                  if (redirect_s) begin
                     req_addr_r <= PCBranchD;
                     pcf_r      <= target_pc4_s;
                  end else begin
                     req_addr_r <= pcf_r;
                     pcf_r      <= plus4(pcf_r);
                  end
                  state_r <= ST_FETCH;
               end else begin
                  if (redirect_s) begin
                     pcf_r <= PCBranchD;
                  end else begin
                     pcf_r <= pcf_r;
                  end
                  state_r <= ST_DISCARD;
               end
            end

            default: begin
               state_r <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A transaction-level model (address pair, hold queue, drop flag) predicts every
// output each cycle; directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        PCSrcD = 1'b0;
   logic [31:0] PCBranchD = 32'h0;
   logic        StallD = 1'b0;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck;
   logic [31:0] ImemRData;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int n_checks = 0;
   int n_errors = 0;
   int wait_n   = 0;
   int cnt;

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
      .StallD(StallD), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
      .ImemAck(ImemAck), .ImemRData(ImemRData), .InstrD(InstrD),
      .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   always #5 clk = ~clk;

   // Memory: acks after wait_n waiting cycles, returns data = address.
   always @(posedge clk or posedge rst) begin
      if (rst) cnt <= 0;
      else if (ImemReq && !ImemAck) cnt <= cnt + 1;
      else cnt <= 0;
   end
   assign ImemAck   = ImemReq && (cnt >= wait_n);
   assign ImemRData = ImemAck ? ImemAddr : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_addr, m_next, e_instr, e_pc4;
   logic        e_valid, m_drop, acc, red, had;
   logic [63:0] held[$];
   logic [63:0] item;

   always @(negedge clk) begin
      if (rst) begin
         m_addr  = RESET_PC;
         m_next  = RESET_PC + 32'd4;
         held.delete();
         m_drop  = 1'b0;
         e_instr = 32'h0;
         e_pc4   = 32'h0;
         e_valid = 1'b0;
      end
      check("m_ImemReq",  32'(ImemReq),  32'(!rst && held.size() == 0));
      check("m_ImemAddr", ImemAddr, m_addr);
      check("m_InstrD",   InstrD,   e_instr);
      check("m_PCPlus4D", PCPlus4D, e_pc4);
      check("m_ValidD",   32'(ValidD), 32'(e_valid));
      if (!rst) begin
         had = (held.size() != 0);
         acc = ImemAck && !had;
         red = PCSrcD && !StallD;
         if (!StallD) begin
            if (had) begin
               item    = held.pop_front();
               e_instr = item[63:32];
               e_pc4   = item[31:0];
               e_valid = 1'b1;
            end else if (acc && !m_drop) begin
               e_instr = m_addr;
               e_pc4   = m_addr + 32'd4;
               e_valid = 1'b1;
            end else begin
               e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
            end
            if (red && !DS) begin
               e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
            end
         end else if (acc && !m_drop) begin
            held.push_back({m_addr, m_addr + 32'd4});
         end
         if (acc) begin
            if (red) begin m_addr = PCBranchD; m_next = PCBranchD + 32'd4; end
            else begin m_addr = m_next; m_next = m_next + 32'd4; end
            m_drop = 1'b0;
         end else if (red) begin
            if (had) begin m_addr = PCBranchD; m_next = PCBranchD + 32'd4; end
            else begin
               m_next = PCBranchD;
               if (!DS) m_drop = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input logic s, input logic p, input logic [31:0] t);
      @(posedge clk); #1;
      StallD = s; PCSrcD = p; PCBranchD = t;
      @(negedge clk); #1;
   endtask

   // Leaves the bench in the first cycle after reset release.
   task automatic do_reset(input int w);
      @(posedge clk); #1;
      rst = 1'b1; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0; wait_n = w;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req"},   32'(ImemReq), 32'd0);
      check({tag, "_addr"},  ImemAddr, RESET_PC);
      check({tag, "_instr"}, InstrD, 32'h0);
      check({tag, "_pc4"},   PCPlus4D, 32'h0);
      check({tag, "_valid"}, 32'(ValidD), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, n_checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      check_reset_vals("rst_init");

      // Zero-wait streaming.
      do_reset(0);
      check("t1_c0_req",  32'(ImemReq), 32'd1);
      check("t1_c0_addr", ImemAddr, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      check("t1_c1_instr", InstrD, 32'h0);
      check("t1_c1_pc4",   PCPlus4D, 32'h4);
      check("t1_c1_valid", 32'(ValidD), 32'd1);
      check("t1_c1_addr",  ImemAddr, 32'h4);
      tick(1'b0, 1'b0, 32'h0);
      check("t1_c2_instr", InstrD, 32'h4);
      check("t1_c2_pc4",   PCPlus4D, 32'h8);
      tick(1'b0, 1'b0, 32'h0);
      check("t1_c3_instr", InstrD, 32'h8);
      check("t1_c3_pc4",   PCPlus4D, 32'hC);

      // Stall for three cycles on the ack of address 8.
      do_reset(0);
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 32'h0);
      check("t3_c2_addr",  ImemAddr, 32'h8);
      tick(1'b1, 1'b0, 32'h0);
      check("t3_c3_req",   32'(ImemReq), 32'd0);
      check("t3_c3_instr", InstrD, 32'h4);
      tick(1'b1, 1'b0, 32'h0);
      check("t3_c4_instr", InstrD, 32'h4);
      tick(1'b0, 1'b0, 32'h0);
      check("t3_c5_instr", InstrD, 32'h4);
      tick(1'b0, 1'b0, 32'h0);
      check("t3_c6_instr", InstrD, 32'h8);
      check("t3_c6_pc4",   PCPlus4D, 32'hC);
      check("t3_c6_addr",  ImemAddr, 32'hC);
      tick(1'b0, 1'b0, 32'h0);
      check("t3_c7_instr", InstrD, 32'hC);
      check("t3_c7_addr",  ImemAddr, 32'h10);

      // Redirect to 0x100 while address 8 is acked.
      do_reset(0);
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 32'h100);
      check("t4_c2_addr",  ImemAddr, 32'h8);
      tick(1'b0, 1'b0, 32'h0);
      check("t4_c3_addr",  ImemAddr, 32'h100);
      check("t4_c3_valid", 32'(ValidD), 32'(DS));
      check("t4_c3_instr", InstrD, DS ? 32'h8 : 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      check("t4_c4_instr", InstrD, 32'h100);
      check("t4_c4_pc4",   PCPlus4D, 32'h104);

      // Two wait states.
      do_reset(2);
      tick(1'b0, 1'b0, 32'h0);
      check("t2_c1_addr",  ImemAddr, 32'h0);
      check("t2_c1_valid", 32'(ValidD), 32'd0);
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      check("t2_c3_instr", InstrD, 32'h0);
      check("t2_c3_valid", 32'(ValidD), 32'd1);
      check("t2_c3_addr",  ImemAddr, 32'h4);
      tick(1'b0, 1'b0, 32'h0);
      check("t2_c4_valid", 32'(ValidD), 32'd0);
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      check("t2_c6_instr", InstrD, 32'h4);
      check("t2_c6_pc4",   PCPlus4D, 32'h8);

      // Three wait states, redirect to 0x200 with address 12 outstanding.
      do_reset(3);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 32'h0);
      check("t6_c12_addr", ImemAddr, 32'hC);
      tick(1'b0, 1'b1, 32'h200);
      check("t6_c13_addr", ImemAddr, 32'hC);
      tick(1'b0, 1'b0, 32'h0);
      check("t6_c14_addr", ImemAddr, 32'hC);
      check("t6_c14_req",  32'(ImemReq), 32'd1);
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      check("t6_c16_addr",  ImemAddr, 32'h200);
      check("t6_c16_valid", 32'(ValidD), 32'(DS));
      check("t6_c16_instr", InstrD, DS ? 32'hC : 32'h0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);
      check("t6_c20_instr", InstrD, 32'h200);
      check("t6_c20_valid", 32'(ValidD), 32'd1);
      tick(1'b0, 1'b0, 32'h0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_reset_vals("t6_midrst");

      // Address wrap through 0xFFFF_FFFC.
      do_reset(0);
      tick(1'b0, 1'b1, 32'hFFFF_FFF8);
      tick(1'b0, 1'b0, 32'h0);
      check("wr_c2_addr", ImemAddr, 32'hFFFF_FFF8);
      tick(1'b0, 1'b0, 32'h0);
      check("wr_c3_instr", InstrD, 32'hFFFF_FFF8);
      tick(1'b0, 1'b0, 32'h0);
      check("wr_c4_addr", ImemAddr, 32'h0);
      check("wr_c4_pc4",  PCPlus4D, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      check("wr_c5_instr", InstrD, 32'h0);
      check("wr_c5_pc4",   PCPlus4D, 32'h4);

      // Mixed stalls and redirects, checked by the model only.
      for (int w = 0; w < 3; w++) begin
         do_reset(w);
         for (int i = 0; i < 150; i++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom & 32'h0000_0FFC);
      end

      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
